// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte buffer behind uart_rx, tagging each byte with its BREAK flag.
// Latency: a byte pushed at edge N is on rd_data_o just after edge N; a pop takes effect at the edge.
// Backpressure: rd_ready_i stalls the consumer side; a push into a full FIFO with no pop is dropped and sets sticky overflow_o.
// Ports:
//   clk_i, reset_i (async, active-high)
//   uart_rx_valid_i / uart_rx_data_i / uart_rx_break_i : one-cycle byte report from uart_rx
//   rd_valid_o / rd_ready_i / rd_data_o / rd_break_o   : head entry, valid/ready handshake
//   level_o, empty_o, full_o, almost_full_o            : fill status
//   overflow_o / overflow_clr_i                        : sticky drop flag and its clear
module uart_rx_fifo #(
  parameter int DEPTH       = 16,
  parameter int ALMOST_FULL = 12
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       uart_rx_valid_i,
  input  logic [7:0]                 uart_rx_data_i,
  input  logic                       uart_rx_break_i,
  output logic                       rd_valid_o,
  input  logic                       rd_ready_i,
  output logic [7:0]                 rd_data_o,
  output logic                       rd_break_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic                       almost_full_o,
  output logic                       overflow_o,
  input  logic                       overflow_clr_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AF_LEVEL = PW'(ALMOST_FULL);

  // {break, data}; storage is deliberately left unreset.
  logic [8:0]    mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          overflow_q, overflow_d;

  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic [8:0]    head;

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];

  // The MSB of each pointer is a wrap bit: equal indices with differing
  // wrap bits means the writer is a full lap ahead of the reader.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign pop  = !empty && rd_ready_i;
  // A push into a full FIFO is still taken when the head leaves in the
  // same cycle; it overwrites the slot being vacated.
  assign push = uart_rx_valid_i && (!full || pop);
  assign drop = uart_rx_valid_i && full && !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // A fresh drop wins over a clear in the same cycle.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (overflow_clr_i) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !reset_i) begin
      mem_q[wr_idx] <= {uart_rx_break_i, uart_rx_data_i};
    end
  end

  assign head = mem_q[rd_idx];

  assign rd_valid_o    = !empty;
  assign rd_data_o     = empty ? 8'h00 : head[7:0];
  assign rd_break_o    = empty ? 1'b0  : head[8];
  assign level_o       = wr_ptr_q - rd_ptr_q;
  assign empty_o       = empty;
  assign full_o        = full;
  assign almost_full_o = (level_o >= AF_LEVEL);
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       uart_rx_valid_i;
  logic [7:0] uart_rx_data_i;
  logic       uart_rx_break_i;
  logic       rd_valid_o;
  logic       rd_ready_i;
  logic [7:0] rd_data_o;
  logic       rd_break_o;
  logic [4:0] level_o;
  logic       empty_o;
  logic       full_o;
  logic       almost_full_o;
  logic       overflow_o;
  logic       overflow_clr_i;

  int tests_run = 0;
  int tests_failed = 0;

  uart_rx_fifo #(.DEPTH(16), .ALMOST_FULL(12)) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .uart_rx_valid_i (uart_rx_valid_i),
    .uart_rx_data_i  (uart_rx_data_i),
    .uart_rx_break_i (uart_rx_break_i),
    .rd_valid_o      (rd_valid_o),
    .rd_ready_i      (rd_ready_i),
    .rd_data_o       (rd_data_o),
    .rd_break_o      (rd_break_o),
    .level_o         (level_o),
    .empty_o         (empty_o),
    .full_o          (full_o),
    .almost_full_o   (almost_full_o),
    .overflow_o      (overflow_o),
    .overflow_clr_i  (overflow_clr_i)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock; afterwards we sit 1 time unit past the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic brk);
    uart_rx_valid_i = 1'b1;
    uart_rx_data_i  = d;
    uart_rx_break_i = brk;
    step();
    uart_rx_valid_i = 1'b0;
    uart_rx_data_i  = 8'h00;
    uart_rx_break_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    tests_run++;
    if ({rd_valid_o, rd_data_o, rd_break_o, level_o, empty_o, full_o, almost_full_o, overflow_o}
        !== {1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL %s: vld=%b data=%h brk=%b lvl=%0d e=%b f=%b af=%b ov=%b, expected 0/00/0/0/1/0/0/0",
               tag, rd_valid_o, rd_data_o, rd_break_o, level_o, empty_o, full_o, almost_full_o, overflow_o);
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    #3;
    check_reset_outputs("reset_state");
    @(negedge clk_i);
    reset_i = 1'b0;
    step();
    check_reset_outputs("after_reset_release");
  endtask

  task automatic test_basic();
    push(8'h41, 1'b0);
    push(8'h31, 1'b0);
    tests_run++;
    if (level_o !== 5'd2 || rd_data_o !== 8'h41 || rd_break_o !== 1'b0 || rd_valid_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_two_pushes: lvl=%0d data=%h brk=%b vld=%b, expected 2/41/0/1",
               level_o, rd_data_o, rd_break_o, rd_valid_o);
    end
    rd_ready_i = 1'b1;
    step();
    tests_run++;
    if (rd_data_o !== 8'h31 || level_o !== 5'd1) begin
      tests_failed++;
      $display("FAIL basic_pop1: data=%h lvl=%0d, expected 31/1", rd_data_o, level_o);
    end
    step();
    rd_ready_i = 1'b0;
    tests_run++;
    if (empty_o !== 1'b1 || rd_data_o !== 8'h00 || rd_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_drained: empty=%b data=%h vld=%b, expected 1/00/0", empty_o, rd_data_o, rd_valid_o);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 16; i++) begin
      push(8'(i), 1'b0);
      tests_run++;
      if (level_o !== 5'(i + 1) || almost_full_o !== ((i + 1) >= 12) || full_o !== (i == 15)) begin
        tests_failed++;
        $display("FAIL fill_step%0d: lvl=%0d af=%b full=%b, expected %0d/%b/%b",
                 i, level_o, almost_full_o, full_o, i + 1, (i + 1) >= 12, i == 15);
      end
    end
    push(8'hAA, 1'b0);
    tests_run++;
    if (overflow_o !== 1'b1 || level_o !== 5'd16 || full_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL drop_when_full: ov=%b lvl=%0d full=%b, expected 1/16/1", overflow_o, level_o, full_o);
    end
    rd_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tests_run++;
      if (rd_data_o !== 8'(i) || rd_valid_o !== 1'b1) begin
        tests_failed++;
        $display("FAIL drain_order%0d: data=%h vld=%b, expected %h/1", i, rd_data_o, rd_valid_o, 8'(i));
      end
      step();
    end
    rd_ready_i = 1'b0;
    tests_run++;
    if (empty_o !== 1'b1 || overflow_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL drain_end: empty=%b ov=%b, expected 1/1", empty_o, overflow_o);
    end
    overflow_clr_i = 1'b1;
    step();
    overflow_clr_i = 1'b0;
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i), 1'b0);
    uart_rx_valid_i = 1'b1;
    uart_rx_data_i  = 8'h55;
    rd_ready_i      = 1'b1;
    tests_run++;
    if (rd_data_o !== 8'h10) begin
      tests_failed++;
      $display("FAIL full_head: data=%h, expected 10", rd_data_o);
    end
    step();
    uart_rx_valid_i = 1'b0;
    uart_rx_data_i  = 8'h00;
    tests_run++;
    if (overflow_o !== 1'b0 || level_o !== 5'd16) begin
      tests_failed++;
      $display("FAIL full_push_pop: ov=%b lvl=%0d, expected 0/16", overflow_o, level_o);
    end
    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp;
      exp = (i == 15) ? 8'h55 : 8'h11 + 8'(i);
      tests_run++;
      if (rd_data_o !== exp) begin
        tests_failed++;
        $display("FAIL full_pp_drain%0d: data=%h, expected %h", i, rd_data_o, exp);
      end
      step();
    end
    rd_ready_i = 1'b0;
    tests_run++;
    if (empty_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_pp_empty: empty=%b, expected 1", empty_o);
    end
  endtask

  task automatic test_break();
    push(8'h00, 1'b1);
    push(8'h61, 1'b0);
    tests_run++;
    if (rd_break_o !== 1'b1 || rd_data_o !== 8'h00 || rd_valid_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL break_head: brk=%b data=%h vld=%b, expected 1/00/1", rd_break_o, rd_data_o, rd_valid_o);
    end
    rd_ready_i = 1'b1;
    step();
    tests_run++;
    if (rd_break_o !== 1'b0 || rd_data_o !== 8'h61) begin
      tests_failed++;
      $display("FAIL break_second: brk=%b data=%h, expected 0/61", rd_break_o, rd_data_o);
    end
    step();
    rd_ready_i = 1'b0;
  endtask

  task automatic test_overflow_clr();
    for (int i = 0; i < 17; i++) push(8'hC0 + 8'(i), 1'b0);
    tests_run++;
    if (overflow_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_set: ov=%b, expected 1", overflow_o);
    end
    uart_rx_valid_i = 1'b1;
    overflow_clr_i  = 1'b1;
    step();
    uart_rx_valid_i = 1'b0;
    tests_run++;
    if (overflow_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_set_wins: ov=%b, expected 1", overflow_o);
    end
    step();
    overflow_clr_i = 1'b0;
    tests_run++;
    if (overflow_o !== 1'b0 || level_o !== 5'd16) begin
      tests_failed++;
      $display("FAIL ovf_clear: ov=%b lvl=%0d, expected 0/16", overflow_o, level_o);
    end
    rd_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) step();
    rd_ready_i = 1'b0;
    tests_run++;
    if (empty_o !== 1'b1 || level_o !== 5'd0) begin
      tests_failed++;
      $display("FAIL ovf_drain: empty=%b lvl=%0d, expected 1/0", empty_o, level_o);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) push(8'hE0 + 8'(i), 1'b0);
    tests_run++;
    if (level_o !== 5'd5) begin
      tests_failed++;
      $display("FAIL pre_reset_level: lvl=%0d, expected 5", level_o);
    end
    #2;
    reset_i = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    #1;
    reset_i = 1'b0;
    step();
    check_reset_outputs("post_async_reset");
  endtask

  task automatic test_wrap_random();
    logic [7:0] q[$];
    int sent;
    int got;
    int cyc;
    bit do_pop;
    bit do_push;
    sent = 0;
    got  = 0;
    cyc  = 0;
    while ((got < 40) && (cyc < 1000)) begin
      do_push = (sent < 40) && (q.size() < 16);
      uart_rx_valid_i = do_push;
      uart_rx_data_i  = do_push ? 8'h80 + 8'(sent) : 8'h00;
      rd_ready_i      = 1'($urandom_range(0, 1));
      do_pop = rd_ready_i && (q.size() > 0);
      tests_run++;
      if (rd_valid_o !== (q.size() > 0) || (do_pop && rd_data_o !== q[0])) begin
        tests_failed++;
        $display("FAIL wrap_head cyc%0d: vld=%b data=%h, expected %b/%h",
                 cyc, rd_valid_o, rd_data_o, q.size() > 0, (q.size() > 0) ? q[0] : 8'h00);
      end
      step();
      if (do_pop) begin
        void'(q.pop_front());
        got++;
      end
      if (do_push) begin
        q.push_back(8'h80 + 8'(sent));
        sent++;
      end
      tests_run++;
      if (level_o !== 5'(q.size()) || level_o > 5'd16) begin
        tests_failed++;
        $display("FAIL wrap_level cyc%0d: lvl=%0d, expected %0d", cyc, level_o, q.size());
      end
      cyc++;
    end
    uart_rx_valid_i = 1'b0;
    uart_rx_data_i  = 8'h00;
    rd_ready_i      = 1'b0;
    tests_run++;
    if (got != 40 || empty_o !== 1'b1 || overflow_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_done: received=%0d empty=%b ov=%b, expected 40/1/0", got, empty_o, overflow_o);
    end
  endtask

  initial begin
    reset_i         = 1'b1;
    uart_rx_valid_i = 1'b0;
    uart_rx_data_i  = 8'h00;
    uart_rx_break_i = 1'b0;
    rd_ready_i      = 1'b0;
    overflow_clr_i  = 1'b0;
    test_reset();
    test_basic();
    test_fill_overflow();
    test_full_push_pop();
    test_break();
    test_overflow_clr();
    test_async_reset();
    test_wrap_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer that sits directly downstream of `uart_rx`. It captures every byte that `uart_rx` reports, together with its BREAK flag, into a DEPTH-entry first-word-fall-through FIFO. It presents the bytes to the host logic over a valid/ready interface and reports fill level, almost-full (usable for RTS flow control) and a sticky overflow flag. It decouples the single-cycle `uart_rx_valid` pulse from a consumer that may stall.

## Interface
- `DEPTH`, 16: number of entries; power of two, ≥ 2.
- `ALMOST_FULL`, 12: `almost_full` asserts when `level` ≥ this value; range 1..DEPTH.
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `uart_rx_valid` in 1: one-cycle pulse from `uart_rx`; a received byte is present.
- `uart_rx_data` in 8: received byte; sampled only when `uart_rx_valid`=1.
- `uart_rx_break` in 1: BREAK indication; sampled only when `uart_rx_valid`=1.
- `rd_valid` out 1: head entry available (= !empty).
- `rd_ready` in 1: consumer accepts the head entry.
- `rd_data` out 8: head entry data; 0x00 when empty.
- `rd_break` out 1: head entry BREAK tag; 0 when empty.
- `level` out $clog2(DEPTH)+1: current number of stored entries, 0..DEPTH.
- `empty` out 1: `level`==0.
- `full` out 1: `level`==DEPTH.
- `almost_full` out 1: `level` ≥ ALMOST_FULL.
- `overflow` out 1: sticky; a byte was dropped because the FIFO was full.
- `overflow_clr` in 1: synchronous clear of `overflow`.

## Operation
- Storage is DEPTH × 9 bits ({break, data[7:0]}). The array is not reset.
- Pointers: `wr_ptr` and `rd_ptr`, each $clog2(DEPTH)+1 bits. The MSB is a wrap bit. The index is formed from the low bits and wraps naturally from DEPTH-1 to 0.
- Full is detected when the indices are equal and the wrap bits differ. Empty is detected when both the indices and the wrap bits are equal.
- `level` = `wr_ptr` − `rd_ptr`, computed modulo 2^(ptr width).
- Pop occurs when `rd_valid` && `rd_ready`; `rd_ptr` increments.
- Push is requested when `uart_rx_valid`=1. The push is accepted if !full, or if full and a pop occurs in the same cycle. An accepted push writes {`uart_rx_break`, `uart_rx_data`} at the write index, and `wr_ptr` increments.
- Dropped push occurs when the FIFO is full with no pop. Contents, pointers and `level` are unchanged, and `overflow` is set at that edge.
- `overflow`:
  - Cleared by `overflow_clr`=1.
  - If a new drop and `overflow_clr` occur in the same cycle, set wins and `overflow` stays 1.
- A BREAK entry is stored like any other byte (normally data 0x00 with tag 1). It is never filtered.
- A push and a pop in the same cycle when not empty and not full: both pointers advance and `level` is unchanged.
- A push and `rd_ready` on an empty FIFO: no pop occurs. The entry becomes visible in the next cycle.
- `rd_data` and `rd_break` are a combinational read of the head entry, gated to 0 when empty.

## Timing
- Reset (asynchronous, takes effect immediately without a clock edge):
  - `wr_ptr` = `rd_ptr` = 0, `overflow` = 0.
  - Outputs: `rd_valid`=0, `rd_data`=0x00, `rd_break`=0, `level`=0, `empty`=1, `full`=0, `almost_full`=0, `overflow`=0.
- Reset mid-operation: all stored entries are discarded. A `uart_rx_valid` pulse coincident with reset is lost.
- Write-to-read latency is 1 cycle. For a push at edge N into an empty FIFO, `rd_valid`=1 and the byte appears on `rd_data` from just after edge N.
- Pop takes effect at the edge. The next entry, or the empty state, is visible just after that edge. `rd_ready` may be held high continuously to drain one entry per cycle.
- `level`, `empty`, `full`, `almost_full` and `overflow` are all derived from the registered state and update at the same edge as the push or pop that changes them.
- Back-to-back `uart_rx_valid` on consecutive cycles must be accepted, one entry per cycle. `uart_rx` never produces this, but the bench exercises it.

## Test plan
- Reset release, then push 'A' (0x41) and '1' (0x31) with `rd_ready`=0 → `level`=2, `rd_data`=0x41, `rd_break`=0. Assert `rd_ready` for 2 cycles → 0x41 then 0x31 are popped, then `empty`=1 and `rd_data`=0x00.
- Push 16 bytes 0x00..0x0F with `rd_ready`=0 → `full`=1, `almost_full`=1 from the 12th push, `level`=16. A 17th push of 0xAA → dropped, `overflow`=1, `level`=16, and the drain yields 0x00..0x0F in order.
- FIFO full, push 0x55 coincident with pop → push accepted, `overflow` stays 0, `level` stays 16, and the last entry drained is 0x55.
- Push 0x00 with `uart_rx_break`=1, then 'a' (0x61) → the first head is `rd_break`=1, `rd_data`=0x00; the second is `rd_break`=0, `rd_data`=0x61.
- With `overflow`=1, assert `overflow_clr` in the same cycle as another dropped push → `overflow` stays 1. Then `overflow_clr` alone → `overflow`=0.
- Fill to `level`=5, assert `reset` asynchronously between clock edges → all outputs at reset values immediately. Then push/pop across the 15→0 wrap for 40 entries with random `rd_ready` → data order is preserved and `level` is never > 16.
